// File: rtl/mips32_fetch_unit_if.sv
// rtl/mips32_fetch_unit_if.sv - Instruction memory port and decode handshake bundle for mips32_fetch_unit
interface mips32_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata,
    output id_valid, id_instr, id_pc, id_pc_plus4,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata,
    input  id_valid, id_instr, id_pc, id_pc_plus4,
    output id_ready
  );
endinterface

// File: rtl/mips32_fetch_unit.sv
// rtl/mips32_fetch_unit.sv - MIPS32 fetch front end: PC, imem requests, instruction queue to decode
// Define MIPS32_FETCH_PERF_EN to add the fetched/redirect performance counters.
module mips32_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
`ifdef MIPS32_FETCH_PERF_EN
  output logic [31:0] o_perf_fetched,
  output logic [31:0] o_perf_redirects,
`endif
  mips32_fetch_unit_if.master io_fetch
);
  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam logic [CW:0] QD = QDEPTH[CW:0];

  logic [31:0]   r_pc;
  logic [31:0]   r_tag;
  logic          r_inflight;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_q_instr [QDEPTH];
  logic [31:0]   r_q_pc    [QDEPTH];

  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic [CW:0]   w_credit;
  logic [31:0]   w_head_pc;
  logic          w_unused_ok;

  assign w_pop  = (r_count != '0) && io_fetch.id_ready;
  assign w_push = r_inflight && !i_redirect_valid;
  // Slots already spoken for: held entries plus the word returning now, less the one leaving.
  assign w_credit = {1'b0, r_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
  assign w_issue  = !i_reset && !i_redirect_valid && (w_credit < QD);

  assign w_head_pc   = r_q_pc[r_rd_ptr];
  assign w_unused_ok = ^i_redirect_pc[1:0];

  assign io_fetch.imem_req    = w_issue;
  assign io_fetch.imem_addr   = r_pc;
  assign io_fetch.id_valid    = (r_count != '0);
  assign io_fetch.id_instr    = r_q_instr[r_rd_ptr];
  assign io_fetch.id_pc       = w_head_pc;
  assign io_fetch.id_pc_plus4 = w_head_pc + 32'd4;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc       <= RESET_PC;
      r_tag      <= '0;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      for (int i = 0; i < int'(QDEPTH); i++) begin
        r_q_instr[i] <= '0;
        r_q_pc[i]    <= '0;
      end
    end else if (i_redirect_valid) begin
      r_pc       <= {i_redirect_pc[31:2], 2'b00};
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_q_instr[r_wr_ptr] <= io_fetch.imem_rdata;
        r_q_pc[r_wr_ptr]    <= r_tag;
        r_wr_ptr            <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag <= r_pc;
        r_pc  <= r_pc + 32'd4;
      end
    end
  end

`ifdef MIPS32_FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_redirects;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_perf_fetched   <= '0;
      r_perf_redirects <= '0;
    end else begin
      if (w_issue) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (i_redirect_valid) begin
        r_perf_redirects <= r_perf_redirects + 32'd1;
      end
    end
  end

  assign o_perf_fetched   = r_perf_fetched;
  assign o_perf_redirects = r_perf_redirects;
`endif
endmodule
